// File: rtl/mem88_pkg.sv
// Shared definitions for the mem88 SRAM bridge: FSM state encoding,
// the write-protected ROM region nibble and a byte-lane select helper.
package mem88_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  // address[19:16] value of the region that is read-only when protection is built in
  localparam logic [3:0] ROM_REGION = 4'hF;

  // Lane 0 is the low byte of a 16-bit SRAM word, lane 1 the high byte
  function automatic logic [7:0] lane_byte(input logic [15:0] word, input logic lane);
    return lane ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/mem88_linebuf.sv
// Single-entry line buffer: one 16-bit SRAM word with its word-address tag
// and a valid flag. Whole-word fill from SRAM reads, single-byte update for
// write-through coherence. Fill has priority over a byte update.
module mem88_linebuf (
  input  logic        clock,
  input  logic        resetn,
  input  logic        fill,
  input  logic [18:0] fill_tag,
  input  logic [15:0] fill_word,
  input  logic        byte_we,
  input  logic        lane,
  input  logic [7:0]  byte_data,
  output logic        valid,
  output logic [18:0] tag,
  output logic [15:0] word
);

  logic        valid_reg;
  logic [18:0] tag_reg;

  // Tag and valid: set on fill, cleared only by reset
  always_ff @(posedge clock) begin
    if (!resetn) begin
      valid_reg <= 1'b0;
      tag_reg   <= '0;
    end else if (fill) begin
      valid_reg <= 1'b1;
      tag_reg   <= fill_tag;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic [7:0] byte_reg;

      // Per-lane byte storage: filled from SRAM or patched by a matching write
      always_ff @(posedge clock) begin
        if (!resetn) begin
          byte_reg <= '0;
        end else if (fill) begin
          byte_reg <= fill_word[gi*8 +: 8];
        end else if (byte_we && (lane == 1'(gi))) begin
          byte_reg <= byte_data;
        end
      end

      assign word[gi*8 +: 8] = byte_reg;
    end
  endgenerate

  assign valid = valid_reg;
  assign tag   = tag_reg;

endmodule

// File: rtl/mem88_bridge.sv
// 8-bit core to 16-bit asynchronous SRAM bridge with a one-word read buffer.
// Optional build macro MEM88_ROM_WP_EN: writes to address[19:16]==4'hF are
// suppressed at the SRAM (and in the buffer) but still complete normally.
module mem88_bridge
  import mem88_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [19:0] address,
  input  logic [7:0]  data,
  input  logic        wreq,
  output logic [7:0]  bus,
  output logic        locked,
  output logic [18:0] sram_a,
  input  logic [15:0] sram_d_i,
  output logic [15:0] sram_d_o,
  output logic        sram_d_oe,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [18:0] sram_a_reg;
  logic        lane_reg, wreq_reg, prot_reg;
  logic [7:0]  data_reg;
  logic [7:0]  bus_reg, bus_next;
  logic        locked_reg;
  logic        we_n_reg, oe_n_reg, ub_n_reg, lb_n_reg, d_oe_reg;
  logic        we_n_next, oe_n_next, ub_n_next, lb_n_next, d_oe_next;
  logic        prot;
  logic        cmd_wreq, cmd_lane, cmd_prot, in_wait_next;
  logic        buf_fill, buf_byte_we, buf_valid;
  logic [18:0] buf_tag;
  logic [15:0] buf_word;

`ifdef MEM88_ROM_WP_EN
  assign prot = wreq && (address[19:16] == ROM_REGION);
`else
  assign prot = 1'b0;
`endif

  mem88_linebuf u_linebuf (
    .clock     (clock),
    .resetn    (resetn),
    .fill      (buf_fill),
    .fill_tag  (sram_a_reg),
    .fill_word (sram_d_i),
    .byte_we   (buf_byte_we),
    .lane      (lane_reg),
    .byte_data (data_reg),
    .valid     (buf_valid),
    .tag       (buf_tag),
    .word      (buf_word)
  );

  // Next-state, wait counter, buffer control, read data and strobe intent
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    bus_next    = bus_reg;
    buf_fill    = 1'b0;
    buf_byte_we = 1'b0;
    case (state_reg)
      IDLE: state_next = SETUP;
      SETUP: begin
        if (!wreq && buf_valid && (buf_tag == address[19:1])) begin
          state_next = ACK;
          bus_next   = lane_byte(buf_word, address[0]);
        end else begin
          state_next = WAIT;
          cnt_next   = 4'(WAIT_CYCLES - 1);
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) begin
          state_next = ACK;
          if (!wreq_reg) begin
            buf_fill = 1'b1;
            bus_next = lane_byte(sram_d_i, lane_reg);
          end else begin
            buf_byte_we = buf_valid && (buf_tag == sram_a_reg) && !prot_reg;
          end
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      ACK: state_next = SETUP;
      default: state_next = IDLE;
    endcase

    // Strobes are registered, so they follow the command being entered into WAIT
    cmd_wreq     = (state_reg == SETUP) ? wreq       : wreq_reg;
    cmd_lane     = (state_reg == SETUP) ? address[0] : lane_reg;
    cmd_prot     = (state_reg == SETUP) ? prot       : prot_reg;
    in_wait_next = (state_next == WAIT);
    oe_n_next    = !(in_wait_next && !cmd_wreq);
    we_n_next    = !(in_wait_next && cmd_wreq && !cmd_prot);
    ub_n_next    = !(in_wait_next && (!cmd_wreq || cmd_lane));
    lb_n_next    = !(in_wait_next && (!cmd_wreq || !cmd_lane));
    d_oe_next    = in_wait_next && cmd_wreq;
  end

  // State, counter, latched command and registered outputs
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      sram_a_reg <= '0;
      lane_reg   <= 1'b0;
      wreq_reg   <= 1'b0;
      prot_reg   <= 1'b0;
      data_reg   <= '0;
      bus_reg    <= '0;
      locked_reg <= 1'b0;
      we_n_reg   <= 1'b1;
      oe_n_reg   <= 1'b1;
      ub_n_reg   <= 1'b1;
      lb_n_reg   <= 1'b1;
      d_oe_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      bus_reg    <= bus_next;
      locked_reg <= (state_next == ACK);
      we_n_reg   <= we_n_next;
      oe_n_reg   <= oe_n_next;
      ub_n_reg   <= ub_n_next;
      lb_n_reg   <= lb_n_next;
      d_oe_reg   <= d_oe_next;
      if (state_reg == SETUP) begin
        sram_a_reg <= address[19:1];
        lane_reg   <= address[0];
        wreq_reg   <= wreq;
        prot_reg   <= prot;
        data_reg   <= data;
      end
    end
  end

  assign bus       = bus_reg;
  assign locked    = locked_reg;
  assign sram_a    = sram_a_reg;
  assign sram_d_o  = {data_reg, data_reg};
  assign sram_d_oe = d_oe_reg;
  assign sram_we_n = we_n_reg;
  assign sram_oe_n = oe_n_reg;
  assign sram_ub_n = ub_n_reg;
  assign sram_lb_n = lb_n_reg;

endmodule

// File: tb/tb_mem88_bridge.sv
// Directed bench for mem88_bridge with a behavioural 16-bit SRAM model.
// Honours MEM88_ROM_WP_EN when compiled with it.
module tb_mem88_bridge;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [19:0] address = '0;
  logic [7:0]  data = '0;
  logic        wreq = 1'b0;
  logic [7:0]  bus;
  logic        locked;
  logic [18:0] sram_a;
  logic [15:0] sram_d_i, sram_d_o;
  logic        sram_d_oe, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:524287];

  int          oe_cnt = 0, we_cnt = 0, ubw_cnt = 0, lbw_cnt = 0, lock_cnt = 0;
  logic [15:0] last_do = '0;
  logic [18:0] last_a = '0;

  mem88_bridge #(.WAIT_CYCLES(2)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .address   (address),
    .data      (data),
    .wreq      (wreq),
    .bus       (bus),
    .locked    (locked),
    .sram_a    (sram_a),
    .sram_d_i  (sram_d_i),
    .sram_d_o  (sram_d_o),
    .sram_d_oe (sram_d_oe),
    .sram_we_n (sram_we_n),
    .sram_oe_n (sram_oe_n),
    .sram_ub_n (sram_ub_n),
    .sram_lb_n (sram_lb_n)
  );

  always #5 clock = ~clock;

  // SRAM model: contents loaded while in reset, byte-lane writes at the clock edge
  always @(posedge clock) begin
    if (!resetn) begin
      mem[19'h00008] <= 16'hBEEF;
      mem[19'h78000] <= 16'h3400;
      mem[19'h00080] <= 16'h1234;
      mem[19'h7FFFF] <= 16'hA55A;
    end else if (!sram_we_n) begin
      if (!sram_lb_n) mem[sram_a][7:0]  <= sram_d_o[7:0];
      if (!sram_ub_n) mem[sram_a][15:8] <= sram_d_o[15:8];
    end
  end

  assign sram_d_i = sram_oe_n ? 16'h0000 : mem[sram_a];

  // Bus activity monitor sampled mid-cycle
  always @(negedge clock) begin
    if (!sram_oe_n) begin
      oe_cnt <= oe_cnt + 1;
      last_a <= sram_a;
    end
    if (!sram_we_n) begin
      we_cnt  <= we_cnt + 1;
      ubw_cnt <= ubw_cnt + (sram_ub_n ? 0 : 1);
      lbw_cnt <= lbw_cnt + (sram_lb_n ? 0 : 1);
      last_do <= sram_d_o;
    end
    if (locked) lock_cnt <= lock_cnt + 1;
  end

  // Called at a negedge whose next posedge enters SETUP; returns at the ACK negedge
  task automatic access(input logic [19:0] a, input logic [7:0] d, input logic w,
                        output int lat, output logic [7:0] busv);
    address = a;
    data    = d;
    wreq    = w;
    @(negedge clock);
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!locked && lat < 40);
    busv = bus;
    $display("access %s addr=%05h data=%02h latency=%0d bus=%02h",
             w ? "WR" : "RD", a, d, lat, busv);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (locked !== 1'b0) begin $display("FAIL reset_locked got %b want 0", locked); errors++; end
    checks++;
    if (bus !== 8'h00) begin $display("FAIL reset_bus got %02h want 00", bus); errors++; end
    checks++;
    if ({sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n, sram_d_oe} !== 5'b11110) begin
      $display("FAIL reset_strobes got %b want 11110",
               {sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n, sram_d_oe});
      errors++;
    end
    checks++;
    if (sram_a !== 19'h0) begin $display("FAIL reset_sram_a got %05h want 00000", sram_a); errors++; end
    resetn = 1'b1;
  endtask

  task automatic test_read_miss();
    int lat; logic [7:0] b; int oe0;
    oe0 = oe_cnt;
    access(20'h00010, 8'h00, 1'b0, lat, b);
    checks++;
    if (lat !== 3) begin $display("FAIL miss_latency got %0d want 3", lat); errors++; end
    checks++;
    if (b !== 8'hEF) begin $display("FAIL miss_bus got %02h want EF", b); errors++; end
    checks++;
    if (oe_cnt - oe0 !== 2) begin $display("FAIL miss_oe_cycles got %0d want 2", oe_cnt - oe0); errors++; end
  endtask

  task automatic test_read_hit();
    int lat; logic [7:0] b; int oe0;
    oe0 = oe_cnt;
    access(20'h00011, 8'h00, 1'b0, lat, b);
    checks++;
    if (lat !== 1) begin $display("FAIL hit_latency got %0d want 1", lat); errors++; end
    checks++;
    if (b !== 8'hBE) begin $display("FAIL hit_bus got %02h want BE", b); errors++; end
    checks++;
    if (oe_cnt - oe0 !== 0) begin $display("FAIL hit_oe_cycles got %0d want 0", oe_cnt - oe0); errors++; end
  endtask

  task automatic test_write_through();
    int lat; logic [7:0] b; int we0, ub0, lb0;
    we0 = we_cnt; ub0 = ubw_cnt; lb0 = lbw_cnt;
    access(20'h00011, 8'h5A, 1'b1, lat, b);
    checks++;
    if (lat !== 3) begin $display("FAIL wr_latency got %0d want 3", lat); errors++; end
    checks++;
    if (we_cnt - we0 !== 2) begin $display("FAIL wr_we_cycles got %0d want 2", we_cnt - we0); errors++; end
    checks++;
    if (ubw_cnt - ub0 !== 2 || lbw_cnt - lb0 !== 0) begin
      $display("FAIL wr_lanes got ub=%0d lb=%0d want ub=2 lb=0", ubw_cnt - ub0, lbw_cnt - lb0);
      errors++;
    end
    checks++;
    if (last_do !== 16'h5A5A) begin $display("FAIL wr_data_out got %04h want 5A5A", last_do); errors++; end
    checks++;
    if (mem[19'h00008] !== 16'h5AEF) begin $display("FAIL wr_sram_word got %04h want 5AEF", mem[19'h00008]); errors++; end
    checks++;
    if (b !== 8'hBE) begin $display("FAIL wr_bus_hold got %02h want BE", b); errors++; end
  endtask

  task automatic test_back_to_back();
    int lat; logic [7:0] b;
    access(20'h00011, 8'h00, 1'b0, lat, b);
    checks++;
    if (lat !== 1 || b !== 8'h5A) begin $display("FAIL b2b_same_lane got lat=%0d bus=%02h want lat=1 bus=5A", lat, b); errors++; end
    access(20'h00010, 8'h00, 1'b0, lat, b);
    checks++;
    if (lat !== 1 || b !== 8'hEF) begin $display("FAIL b2b_other_lane got lat=%0d bus=%02h want lat=1 bus=EF", lat, b); errors++; end
  endtask

  task automatic test_rom_write();
    int lat; logic [7:0] b; int we0;
    we0 = we_cnt;
    access(20'hF0000, 8'h12, 1'b1, lat, b);
    checks++;
    if (lat !== 3 || !locked) begin $display("FAIL rom_latency got %0d want 3", lat); errors++; end
`ifdef MEM88_ROM_WP_EN
    checks++;
    if (we_cnt - we0 !== 0) begin $display("FAIL rom_we_cycles got %0d want 0", we_cnt - we0); errors++; end
    checks++;
    if (mem[19'h78000] !== 16'h3400) begin $display("FAIL rom_sram_word got %04h want 3400", mem[19'h78000]); errors++; end
`else
    checks++;
    if (we_cnt - we0 !== 2) begin $display("FAIL rom_we_cycles got %0d want 2", we_cnt - we0); errors++; end
    checks++;
    if (mem[19'h78000] !== 16'h3412) begin $display("FAIL rom_sram_word got %04h want 3412", mem[19'h78000]); errors++; end
`endif
  endtask

  task automatic test_top_address();
    int lat; logic [7:0] b;
    access(20'hFFFFF, 8'h00, 1'b0, lat, b);
    checks++;
    if (lat !== 3) begin $display("FAIL top_latency got %0d want 3", lat); errors++; end
    checks++;
    if (last_a !== 19'h7FFFF) begin $display("FAIL top_sram_a got %05h want 7FFFF", last_a); errors++; end
    checks++;
    if (b !== 8'hA5) begin $display("FAIL top_bus got %02h want A5", b); errors++; end
  endtask

  task automatic test_reset_abort();
    int lat; logic [7:0] b; int lk0;
    address = 20'h00100;
    data    = 8'h00;
    wreq    = 1'b0;
    @(negedge clock);               // SETUP
    @(negedge clock);               // first WAIT cycle
    checks++;
    if (sram_oe_n !== 1'b0) begin $display("FAIL abort_in_wait got oe_n=%b want 0", sram_oe_n); errors++; end
    lk0 = lock_cnt;
    resetn = 1'b0;
    @(negedge clock);
    checks++;
    if ({sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n, sram_d_oe} !== 5'b11110) begin
      $display("FAIL abort_strobes got %b want 11110",
               {sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n, sram_d_oe});
      errors++;
    end
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);               // IDLE then SETUP region, no ACK possible yet
    checks++;
    if (lock_cnt - lk0 !== 0) begin $display("FAIL abort_locked got %0d pulses want 0", lock_cnt - lk0); errors++; end
    $display("access RD addr=00100 aborted by reset");
    // Bring the bridge back into a known SETUP alignment via a fresh reset release
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    // Buffer was invalidated: a previously buffered word must miss again
    access(20'hFFFFF, 8'h00, 1'b0, lat, b);
    checks++;
    if (lat !== 3 || b !== 8'hA5) begin $display("FAIL abort_buffer_invalid got lat=%0d bus=%02h want lat=3 bus=A5", lat, b); errors++; end
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_through();
    test_back_to_back();
    test_rom_write();
    test_top_address();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem88_bridge.md
MEM88_BRIDGE -- requirements
Module: mem88_bridge

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2: SRAM strobe cycles per access; legal range 1..15.
REQ-002 SHALL have port clock, input, 1: rising-edge system clock.
REQ-003 SHALL have port resetn, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port address, input, 20: core byte address, sampled in SETUP.
REQ-005 SHALL have port data, input, 8: core write byte, sampled in SETUP.
REQ-006 SHALL have port wreq, input, 1: core write request, sampled in SETUP.
REQ-007 SHALL have port bus, output, 8: read byte to core, valid while locked=1.
REQ-008 SHALL have port locked, output, 1: core clock-enable, high exactly one cycle per completed transaction.
REQ-009 SHALL have port sram_a, output, 19: SRAM word address.
REQ-010 SHALL have ports sram_d_i (input, 16), sram_d_o (output, 16) and sram_d_oe (output, 1): SRAM data in, data out and output enable.
REQ-011 SHALL have ports sram_we_n, sram_oe_n, sram_ub_n and sram_lb_n (outputs, 1 each, active-low): SRAM write, read and byte-lane strobes.

Function
REQ-012 SHALL split the address as sram_a=address[19:1], lane=address[0]; lane 0 is the low byte (lb), lane 1 is the high byte (ub).
REQ-013 SHALL implement states IDLE, SETUP, WAIT and ACK with transitions IDLE->SETUP, SETUP->WAIT|ACK, WAIT->ACK and ACK->SETUP.
REQ-014 SETUP SHALL latch address/data/wreq and drive sram_a.
REQ-015 A read in SETUP SHALL go directly to ACK if the line buffer is valid and its tag equals address[19:1] (hit); otherwise it SHALL go to WAIT.
REQ-016 A write in SETUP SHALL go to WAIT.
REQ-017 WAIT SHALL last exactly WAIT_CYCLES cycles, with a 4-bit down-counter.
REQ-018 During a read in WAIT: sram_oe_n=0, sram_ub_n=sram_lb_n=0, sram_d_oe=0.
REQ-019 On the last WAIT cycle of a read, SHALL capture sram_d_i into the line buffer, set the tag to sram_a and set valid.
REQ-020 During a write in WAIT: sram_d_oe=1, sram_d_o={data,data}, sram_we_n=0, and only the selected lane strobe low.
REQ-021 A write whose word matches the buffer tag SHALL update that buffer byte on the last WAIT cycle (write-through coherence).
REQ-022 In ACK: locked=1; bus=buffer byte selected by lane for reads, previous bus value held for writes; all SRAM strobes high.
REQ-023 Latency from SETUP entry to locked high SHALL be 1 cycle for a read hit and 1+WAIT_CYCLES cycles for a read miss or any write.
REQ-024 locked SHALL be registered and SHALL be 0 in every state except ACK.
REQ-025 Address 0xFFFFF SHALL map to sram_a=0x7FFFF, ub lane; there is no wrap into other words.
REQ-026 Back-to-back accesses to the same word SHALL each complete; a write followed by a read of the other lane SHALL hit.

Reset
REQ-027 On resetn=0 at a clock edge: state=IDLE, locked=0, bus=0x00, sram_we_n=sram_oe_n=sram_ub_n=sram_lb_n=1, sram_d_oe=0, sram_a=0, buffer valid=0, counter=0.
REQ-028 Reset asserted mid-WAIT SHALL abort the access with strobes released at that same edge; no buffer update and no locked pulse.
REQ-029 IDLE SHALL last exactly one cycle after resetn rises.

Configuration
REQ-030 With MEM88_ROM_WP_EN defined, writes with address[19:16]==4'hF SHALL keep sram_we_n=1 and the buffer unchanged, yet complete with normal write latency and a locked pulse.
REQ-031 Without MEM88_ROM_WP_EN, the whole 1 MB SHALL be writable.

Structure
REQ-032 A shared package SHALL hold the state enum (IDLE, SETUP, WAIT, ACK) and the ROM-region constant 4'hF.
REQ-033 The line buffer (tag, valid, 16-bit word, byte-write) SHALL be a sub-module mem88_linebuf; the FSM and strobes stay in mem88_bridge.

Verification
REQ-034 Reset then read 0x00010 with SRAM word 0x00008=0xBEEF, WAIT_CYCLES=2 -> locked after 3 cycles, bus=0xEF; sram_oe_n low exactly 2 cycles.
REQ-035 Immediately read 0x00011 -> hit, locked 1 cycle after SETUP, bus=0xBE, sram_oe_n stays high.
REQ-036 Write 0x5A to 0x00011 -> sram_we_n low 2 cycles, ub low, lb high, sram_d_o=0x5A5A; next read of 0x00011 hits with bus=0x5A.
REQ-037 With MEM88_ROM_WP_EN, write 0x12 to 0xF0000 -> sram_we_n never low, locked pulses; without the macro, SRAM word 0x78000 low byte=0x12.
REQ-038 Read 0xFFFFF -> sram_a=0x7FFFF, bus=high byte; resetn low on the 1st WAIT cycle of a read miss -> strobes high next edge, no locked pulse, buffer invalid.
